// File: rtl/clk_meter_pkg.sv
// Shared FSM type and sizing helpers for the clock frequency meter.
// Latency: none, compile-time declarations only.
// Backpressure: none, no datapath in this file.
package clk_meter_pkg;

    // Meter lifecycle: idle, counting towards lock, locked.
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } meter_state_t;

    // Default synchronizer depth for slow asynchronous status inputs.
    localparam int SYNC_STAGES_DEF = 2;

    // Width of a counter that runs 0..gate_cycles-1. A floor of 1 bit keeps
    // degenerate parameter sets elaborating so the top-level checks can report them.
    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/clk_freq_meter_sync_edge.sv
// Synchronizes an asynchronous level and flags every transition (both polarities).
// Latency: edge_o rises STAGES cycles after the input change and is counted one cycle later.
// Backpressure: none, free-running and always sampling.
module sync_edge
    import clk_meter_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic edge_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    if (STAGES < 1) begin : g_chk_stages
        $error("sync_edge: STAGES must be at least 1");
    end

    // Shift chain into the clock domain, plus one history flop behind the last stage.
    // The history keeps tracking even while the consumer ignores edges, so a
    // consumer that is re-enabled never sees a stale difference.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(async_i);
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign edge_o = sync_q[STAGES-1] ^ hist_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts toggles of a divided generated clock per gate window and qualifies lock.
// Latency: window results appear the cycle after gate==GATE_CYCLES-1; tick to count is 3 cycles.
// Backpressure: none, results are single-cycle pulses with levels held until the next window.
module clk_freq_meter
    import clk_meter_pkg::*;
#(
    parameter int GATE_CYCLES  = 100000,
    parameter int CNT_W        = 20,
    parameter int EXP_MIN      = 24900,
    parameter int EXP_MAX      = 25100,
    parameter int GOOD_WINDOWS = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o,
    output logic             count_valid_o,
    output logic             in_range_o,
    output logic             stalled_o,
    output logic             locked_o
);

    localparam int                GATE_W    = gate_cnt_w(GATE_CYCLES);
    localparam int                GOOD_W    = $clog2(GOOD_WINDOWS + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GOOD_W-1:0] GOOD_TGT  = GOOD_W'(GOOD_WINDOWS);

    if (EXP_MIN > EXP_MAX) begin : g_chk_band
        $error("clk_freq_meter: EXP_MIN must not exceed EXP_MAX");
    end
    if (GATE_CYCLES < 2) begin : g_chk_gate
        $error("clk_freq_meter: GATE_CYCLES must be at least 2");
    end
    if (GOOD_WINDOWS < 1) begin : g_chk_good
        $error("clk_freq_meter: GOOD_WINDOWS must be at least 1");
    end

    logic                edge_det;
    logic                win_end;
    logic                win_ok;
    logic [CNT_W-1:0]    edge_sum;
    logic [31:0]         sum_ext;
    logic [GOOD_W-1:0]   good_inc;

    logic [GATE_W-1:0]   gate_q,     gate_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [GOOD_W-1:0]   good_q,     good_d;
    meter_state_t        state_q,    state_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic                valid_q,    valid_d;
    logic                in_range_q, in_range_d;
    logic                stalled_q,  stalled_d;

    sync_edge #(
        .STAGES (SYNC_STAGES_DEF)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (tick_i),
        .edge_o  (edge_det)
    );

    // Closing count including an edge seen on this cycle, saturating at all-ones.
    // Saturation needs no special case in the band compare: an all-ones count only
    // lands in range when EXP_MAX reaches that value.
    always_comb begin
        edge_sum = edge_cnt_q;
        if (edge_det && (edge_cnt_q != CNT_MAX)) begin
            edge_sum = edge_cnt_q + CNT_W'(1);
        end
        sum_ext  = 32'(edge_sum);
        win_end  = enable_i && (gate_q == GATE_LAST);
        win_ok   = (sum_ext >= 32'(EXP_MIN)) && (sum_ext <= 32'(EXP_MAX));
        good_inc = good_q + GOOD_W'(1);
    end

    // Gate and edge counters: run only while enabled, restart together at window end
    // so an edge on the last gate cycle lands in the closing window exactly once.
    always_comb begin
        gate_d     = '0;
        edge_cnt_d = '0;
        if (enable_i) begin
            if (win_end) begin
                gate_d     = '0;
                edge_cnt_d = '0;
            end else begin
                gate_d     = gate_q + GATE_W'(1);
                edge_cnt_d = edge_sum;
            end
        end
    end

    // Window reporting and lock qualification; disabling wipes status and the
    // partial window without producing a result pulse.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        stalled_d  = stalled_q;

        if (!enable_i) begin
            state_d    = DISABLED;
            good_d     = '0;
            count_d    = '0;
            in_range_d = 1'b0;
            stalled_d  = 1'b0;
        end else begin
            if (state_q == DISABLED) begin
                state_d = ACQUIRE;
                good_d  = '0;
            end
            if (win_end) begin
                count_d    = edge_sum;
                valid_d    = 1'b1;
                in_range_d = win_ok;
                stalled_d  = (edge_sum == '0);
                case (state_q)
                    LOCKED: begin
                        if (!win_ok) begin
                            state_d = ACQUIRE;
                            good_d  = '0;
                        end
                    end
                    default: begin
                        state_d = ACQUIRE;
                        if (!win_ok) begin
                            good_d = '0;
                        end else if (good_inc >= GOOD_TGT) begin
                            state_d = LOCKED;
                            good_d  = GOOD_TGT;
                        end else begin
                            good_d = good_inc;
                        end
                    end
                endcase
            end
        end
    end

    // State registers; everything clears asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gate_q     <= '0;
            edge_cnt_q <= '0;
            good_q     <= '0;
            state_q    <= DISABLED;
            count_q    <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            good_q     <= good_d;
            state_q    <= state_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            stalled_q  <= stalled_d;
        end
    end

    // Windows are at least two cycles long, so result pulses never touch.
    a_valid_single: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count_valid_o |=> !count_valid_o);

    assign count_o       = count_q;
    assign count_valid_o = valid_q;
    assign in_range_o    = in_range_q;
    assign stalled_o     = stalled_q;
    assign locked_o      = (state_q == LOCKED);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter with a window-aligned tick generator.
// Latency: results checked one clock after each count_valid_o pulse is sampled.
// Backpressure: not applicable.
module tb_clk_freq_meter;

    localparam int GATE = 1000;
    localparam int CW   = 12;
    localparam int EMIN = 240;
    localparam int EMAX = 260;
    localparam int GW   = 4;

    logic          clk_i    = 1'b0;
    logic          rst_n_i  = 1'b0;
    logic          enable_i = 1'b0;
    logic          tick_i   = 1'b0;
    logic [CW-1:0] count_o;
    logic          count_valid_o;
    logic          in_range_o;
    logic          stalled_o;
    logic          locked_o;

    int checks = 0;
    int errors = 0;

    // Tick pattern for one window: r toggles spread evenly, rotated by ph,
    // plus one forced toggle at position xp (-1 = none).
    typedef struct {
        int r;
        int ph;
        int xp;
    } gcfg_t;

    gcfg_t cfg_q[$];
    gcfg_t cur;
    bit    gen_on = 1'b0;
    int    gpos   = 0;

    clk_freq_meter #(
        .GATE_CYCLES  (GATE),
        .CNT_W        (CW),
        .EXP_MIN      (EMIN),
        .EXP_MAX      (EMAX),
        .GOOD_WINDOWS (GW)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .enable_i      (enable_i),
        .tick_i        (tick_i),
        .count_o       (count_o),
        .count_valid_o (count_valid_o),
        .in_range_o    (in_range_o),
        .stalled_o     (stalled_o),
        .locked_o      (locked_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit tog_at(input int p, input gcfg_t c);
        int pp;
        if (p == c.xp) return 1'b1;
        pp = (p + c.ph) % GATE;
        return ((pp + 1) * c.r / GATE) != (pp * c.r / GATE);
    endfunction

    // gpos is the gate position at which a toggle driven now gets counted
    // (three cycles of synchronizer/count latency ahead).
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (gen_on) begin
                if (gpos == 0 && cfg_q.size() > 0) cur = cfg_q.pop_front();
                if (tog_at(gpos, cur)) tick_i = ~tick_i;
                gpos = (gpos == GATE - 1) ? 0 : gpos + 1;
            end
        end
    end

    task automatic push(input int r, input int ph, input int xp);
        gcfg_t c;
        c.r = r; c.ph = ph; c.xp = xp;
        cfg_q.push_back(c);
    endtask

    task automatic start(input int r);
        @(posedge clk_i);
        #1;
        cur.r = r; cur.ph = 0; cur.xp = -1;
        gpos     = 2;
        gen_on   = 1'b1;
        enable_i = 1'b1;
    endtask

    task automatic wait_valid(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < GATE + 100) begin
            @(posedge clk_i);
            #1;
            n++;
            if (count_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n_i  = 1'b0;
        enable_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if ({count_valid_o, in_range_o, stalled_o, locked_o} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {count_valid_o, in_range_o, stalled_o, locked_o}); end
        rst_n_i = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        checks++; if ({count_valid_o, locked_o} !== 2'b00 || count_o !== '0) begin errors++; $display("FAIL idle_disabled: got valid/locked %b count %0d expected 00/0", {count_valid_o, locked_o}, count_o); end
    endtask

    task automatic test_nominal_lock;
        int n; bit ok; logic exp_l;
        start(250);
        for (int w = 1; w <= 4; w++) begin
            wait_valid(n, ok);
            exp_l = (w == GW);
            checks++; if (!ok || n != GATE) begin errors++; $display("FAIL nominal_interval w%0d: got %0d cycles (seen %0d) expected %0d", w, n, ok, GATE); end
            checks++; if (count_o !== CW'(250)) begin errors++; $display("FAIL nominal_count w%0d: got %0d expected 250", w, count_o); end
            checks++; if (in_range_o !== 1'b1 || stalled_o !== 1'b0) begin errors++; $display("FAIL nominal_status w%0d: got in_range %b stalled %b expected 1 0", w, in_range_o, stalled_o); end
            checks++; if (locked_o !== exp_l) begin errors++; $display("FAIL nominal_locked w%0d: got %b expected %b", w, locked_o, exp_l); end
        end
        @(posedge clk_i);
        #1;
        checks++; if (count_valid_o !== 1'b0) begin errors++; $display("FAIL valid_width: got %b expected 0", count_valid_o); end
    endtask

    task automatic test_loss_of_lock;
        int n; bit ok;
        int e_cnt[7] = '{250, 333, 333, 250, 250, 250, 250};
        bit e_inr[7] = '{1, 0, 0, 1, 1, 1, 1};
        bit e_lck[7] = '{1, 0, 0, 0, 0, 0, 1};
        push(333, 0, -1);
        for (int i = 0; i < 7; i++) begin
            wait_valid(n, ok);
            checks++; if (!ok || count_o !== CW'(e_cnt[i])) begin errors++; $display("FAIL loss_count w%0d: got %0d (seen %0d) expected %0d", i + 5, count_o, ok, e_cnt[i]); end
            checks++; if (in_range_o !== e_inr[i] || locked_o !== e_lck[i]) begin errors++; $display("FAIL loss_status w%0d: got in_range %b locked %b expected %b %b", i + 5, in_range_o, locked_o, e_inr[i], e_lck[i]); end
            if (i == 1) push(250, 0, -1);
        end
    endtask

    task automatic test_stall;
        int n; bit ok;
        int e_cnt[4] = '{250, 0, 0, 0};
        bit e_stl[4] = '{0, 1, 1, 1};
        bit e_lck[4] = '{1, 0, 0, 0};
        push(0, 0, -1);
        for (int i = 0; i < 4; i++) begin
            wait_valid(n, ok);
            checks++; if (!ok || count_o !== CW'(e_cnt[i])) begin errors++; $display("FAIL stall_count w%0d: got %0d (seen %0d) expected %0d", i, count_o, ok, e_cnt[i]); end
            checks++; if (stalled_o !== e_stl[i] || locked_o !== e_lck[i] || in_range_o !== !e_stl[i]) begin errors++; $display("FAIL stall_status w%0d: got stalled %b locked %b in_range %b expected %b %b %b", i, stalled_o, locked_o, in_range_o, e_stl[i], e_lck[i], !e_stl[i]); end
        end
    endtask

    task automatic test_boundaries;
        int n; bit ok;
        int e_cnt[12] = '{0, 240, 260, 261, 240, 260, 250, 239, 250, 250, 250, 260};
        bit e_inr[12] = '{0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1};
        bit e_lck[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 1; i < 12; i++) push(e_cnt[i], 0, -1);
        for (int i = 0; i < 12; i++) begin
            wait_valid(n, ok);
            checks++; if (!ok || count_o !== CW'(e_cnt[i])) begin errors++; $display("FAIL bound_count w%0d: got %0d (seen %0d) expected %0d", i, count_o, ok, e_cnt[i]); end
            checks++; if (in_range_o !== e_inr[i] || locked_o !== e_lck[i]) begin errors++; $display("FAIL bound_status w%0d: got in_range %b locked %b expected %b %b", i, in_range_o, locked_o, e_inr[i], e_lck[i]); end
        end
    endtask

    task automatic test_disable;
        int n; bit ok; int pulses;
        repeat (500) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        gen_on   = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (count_o !== '0) begin errors++; $display("FAIL disable_count: got %0d expected 0", count_o); end
        checks++; if ({count_valid_o, in_range_o, stalled_o, locked_o} !== 4'b0000) begin errors++; $display("FAIL disable_flags: got %b expected 0000", {count_valid_o, in_range_o, stalled_o, locked_o}); end
        pulses = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk_i);
            #1;
            if (count_valid_o) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL disable_pulses: got %0d expected 0", pulses); end
        start(250);
        wait_valid(n, ok);
        checks++; if (!ok || n != GATE) begin errors++; $display("FAIL reenable_interval: got %0d cycles (seen %0d) expected %0d", n, ok, GATE); end
        checks++; if (count_o !== CW'(250) || in_range_o !== 1'b1 || locked_o !== 1'b0) begin errors++; $display("FAIL reenable_result: got count %0d in_range %b locked %b expected 250 1 0", count_o, in_range_o, locked_o); end
    endtask

    task automatic test_window_edge;
        int n; bit ok;
        int e_cnt[3] = '{250, 251, 250};
        bit e_lck[3] = '{0, 0, 1};
        push(250, 2, GATE - 1);
        push(250, 0, -1);
        for (int i = 0; i < 3; i++) begin
            wait_valid(n, ok);
            checks++; if (!ok || count_o !== CW'(e_cnt[i])) begin errors++; $display("FAIL edge_count w%0d: got %0d (seen %0d) expected %0d", i, count_o, ok, e_cnt[i]); end
            checks++; if (in_range_o !== 1'b1 || locked_o !== e_lck[i]) begin errors++; $display("FAIL edge_status w%0d: got in_range %b locked %b expected 1 %b", i, in_range_o, locked_o, e_lck[i]); end
        end
    endtask

    task automatic test_async_reset;
        repeat (300) @(posedge clk_i);
        #1;
        checks++; if (locked_o !== 1'b1 || count_o !== CW'(250)) begin errors++; $display("FAIL pre_reset: got locked %b count %0d expected 1 250", locked_o, count_o); end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++; if (count_o !== '0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", count_o); end
        checks++; if ({count_valid_o, in_range_o, stalled_o, locked_o} !== 4'b0000) begin errors++; $display("FAIL async_reset_flags: got %b expected 0000", {count_valid_o, in_range_o, stalled_o, locked_o}); end
        enable_i = 1'b0;
        gen_on   = 1'b0;
        #12;
        rst_n_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        checks++; if (locked_o !== 1'b0 || count_o !== '0) begin errors++; $display("FAIL post_reset: got locked %b count %0d expected 0 0", locked_o, count_o); end
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_loss_of_lock();
        test_stall();
        test_boundaries();
        test_disable();
        test_window_edge();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
